// File: rtl/sram_mp_be_init.sv
// sram_mp_be_init: multi-ported SRAM with N write ports, M read ports and
// per-byte write enables. Higher-index write ports win each byte lane; a
// lower port that loses an enabled lane to a higher port at the same address
// gets a one-cycle wr_conflict pulse. An init state machine fills every
// entry with INIT_VALUE after reset or on init_req, so the array itself has
// no reset. Read latency is 0 (combinational) or 1 (registered).
//
// Optional feature, macro SRAM_WR_BYPASS_EN:
//   defined   - a read that hits a same-cycle write returns the merged,
//               write-first data (same lane priority as the array write).
//   undefined - read-before-write; no path from write inputs to data_out.
module sram_mp_be_init #(
   parameter int                    SIZE         = 256,
   parameter int                    DATA_WIDTH   = 64,
   parameter int                    RD_PORTS     = 3,
   parameter int                    WR_PORTS     = 2,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
   localparam int                   AW           = $clog2(SIZE),
   localparam int                   NB           = DATA_WIDTH / 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  init_req,
   output logic                                  init_busy,
   input  logic [WR_PORTS-1:0]                   wr_en,
   input  logic [WR_PORTS-1:0][AW-1:0]           write_address,
   input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]   new_data,
   input  logic [WR_PORTS-1:0][NB-1:0]           wr_be,
   output logic [WR_PORTS-1:0]                   wr_conflict,
   input  logic [RD_PORTS-1:0]                   rd_en,
   input  logic [RD_PORTS-1:0][AW-1:0]           read_address,
   output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]   data_out,
   output logic [RD_PORTS-1:0]                   rd_valid
);

   // Elaboration-time sanity checks on the configuration.
   if (SIZE < 2) begin : g_bad_size
      $error("sram_mp_be_init: SIZE must be at least 2");
   end
   if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("sram_mp_be_init: DATA_WIDTH must be a multiple of 8");
   end
   if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
      $error("sram_mp_be_init: READ_LATENCY must be 0 or 1");
   end

   localparam logic [31:0]   SIZE_U   = 32'(SIZE);
   localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_e;

   state_e                                state_q, state_d;
   logic [AW-1:0]                         cnt_q, cnt_d;
   logic [WR_PORTS-1:0]                   wr_conflict_q, wr_conflict_d;
   logic [WR_PORTS-1:0]                   wr_ok;
   logic [RD_PORTS-1:0][DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]                 mem_q [SIZE];

   // True when an address falls inside the array (SIZE need not be 2**AW).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (32'(a) < SIZE_U);
   endfunction

   assign init_busy   = (state_q == ST_INIT);
   assign wr_conflict = wr_conflict_q;

   // Qualify each write port: enabled, not initialising, address in range.
   always_comb begin
      for (int p = 0; p < WR_PORTS; p++) begin
         wr_ok[p] = wr_en[p] & ~init_busy & addr_ok(write_address[p]);
      end
   end

   // Init FSM next state: INIT sweeps cnt from 0 to SIZE-1, IDLE waits for init_req.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == LAST_IDX) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         ST_IDLE: begin
            if (init_req) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // A port conflicts when a higher-index port writes an overlapping lane at the same address.
   always_comb begin
      wr_conflict_d = '0;
      for (int i = 0; i < WR_PORTS; i++) begin
         for (int j = i + 1; j < WR_PORTS; j++) begin
            if (wr_ok[i] && wr_ok[j] &&
                (write_address[i] == write_address[j]) &&
                |(wr_be[i] & wr_be[j])) begin
               wr_conflict_d[i] = 1'b1;
            end
         end
      end
   end

   // Control registers: FSM state, init counter and conflict pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q       <= ST_INIT;
         cnt_q         <= '0;
         wr_conflict_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   // Array write: init sweep, or byte-lane writes with the highest port applied last.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset on purpose; the init FSM clears it, which
      // keeps it mappable onto SRAM macros instead of thousands of reset flops.
      if (init_busy) begin
         mem_q[cnt_q] <= INIT_VALUE;
      end else begin
         for (int p = 0; p < WR_PORTS; p++) begin
            for (int b = 0; b < NB; b++) begin
               if (wr_ok[p] && wr_be[p][b]) begin
                  mem_q[write_address[p]][8*b +: 8] <= new_data[p][8*b +: 8];
               end
            end
         end
      end
   end

   // Read word per port: out-of-range reads give zero; optional write-first merge.
   always_comb begin
      for (int r = 0; r < RD_PORTS; r++) begin
         rd_word[r] = '0;
         if (addr_ok(read_address[r])) begin
            rd_word[r] = mem_q[read_address[r]];
`ifdef SRAM_WR_BYPASS_EN
            for (int p = 0; p < WR_PORTS; p++) begin
               for (int b = 0; b < NB; b++) begin
                  if (wr_ok[p] && wr_be[p][b] &&
                      (write_address[p] == read_address[r])) begin
                     rd_word[r][8*b +: 8] = new_data[p][8*b +: 8];
                  end
               end
            end
`endif
         end
      end
   end

   if (READ_LATENCY == 0) begin : g_lat0
      assign data_out = rd_word;
      assign rd_valid = rd_en & {RD_PORTS{~init_busy}};
   end else begin : g_lat1
      logic [RD_PORTS-1:0][DATA_WIDTH-1:0] data_out_q;
      logic [RD_PORTS-1:0]                 rd_valid_q;

      // Registered read: capture data on rd_en, hold otherwise; valid only outside init.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= '0;
         end else begin
            rd_valid_q <= rd_en & {RD_PORTS{~init_busy}};
            for (int r = 0; r < RD_PORTS; r++) begin
               if (rd_en[r]) begin
                  data_out_q[r] <= rd_word[r];
               end
            end
         end
      end

      assign data_out = data_out_q;
      assign rd_valid = rd_valid_q;
   end

endmodule

// File: tb/tb_sram_mp_be_init.sv
// Directed bench for sram_mp_be_init: a default 256x64 3R/2W registered-read
// instance plus a small 10x16 1R/2W combinational-read instance that covers
// non-power-of-two sizing and out-of-range addresses.
module tb_sram_mp_be_init;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // Main instance (defaults).
   logic                   init_req;
   logic                   init_busy;
   logic [1:0]             wr_en;
   logic [1:0][7:0]        wa;
   logic [1:0][63:0]       nd;
   logic [1:0][7:0]        be;
   logic [1:0]             conf;
   logic [2:0]             rd_en;
   logic [2:0][7:0]        ra;
   logic [2:0][63:0]       dout;
   logic [2:0]             rv;

   // Small instance: SIZE=10, 16-bit, 1 read port, combinational read.
   logic                   s_init_req;
   logic                   s_busy;
   logic [1:0]             s_wr_en;
   logic [1:0][3:0]        s_wa;
   logic [1:0][15:0]       s_nd;
   logic [1:0][1:0]        s_be;
   logic [1:0]             s_conf;
   logic [0:0]             s_rd_en;
   logic [0:0][3:0]        s_ra;
   logic [0:0][15:0]       s_do;
   logic [0:0]             s_rv;

   sram_mp_be_init u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .init_req      (init_req),
      .init_busy     (init_busy),
      .wr_en         (wr_en),
      .write_address (wa),
      .new_data      (nd),
      .wr_be         (be),
      .wr_conflict   (conf),
      .rd_en         (rd_en),
      .read_address  (ra),
      .data_out      (dout),
      .rd_valid      (rv)
   );

   sram_mp_be_init #(
      .SIZE         (10),
      .DATA_WIDTH   (16),
      .RD_PORTS     (1),
      .WR_PORTS     (2),
      .READ_LATENCY (0),
      .INIT_VALUE   (16'h5A5A)
   ) u_small (
      .clk           (clk),
      .rst_n         (rst_n),
      .init_req      (s_init_req),
      .init_busy     (s_busy),
      .wr_en         (s_wr_en),
      .write_address (s_wa),
      .new_data      (s_nd),
      .wr_be         (s_be),
      .wr_conflict   (s_conf),
      .rd_en         (s_rd_en),
      .read_address  (s_ra),
      .data_out      (s_do),
      .rd_valid      (s_rv)
   );

   int n_checks = 0;
   int n_errs   = 0;
   int cycles;
   int s_cycles;

   localparam logic [63:0] VAL_A = 64'hAAAA_AAAA_0123_4567;
   localparam logic [63:0] VAL_B = 64'h89AB_CDEF_5555_5555;
   localparam logic [63:0] VAL_C = 64'hC0C1_C2C3_C4C5_C6C7;
   localparam logic [63:0] VAL_D = 64'hD0D1_D2D3_D4D5_D6D7;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      init_req   = 1'b0;
      wr_en      = '0;
      rd_en      = '0;
      s_init_req = 1'b0;
      s_wr_en    = '0;
      s_rd_en    = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet();
      wa = '0; nd = '0; be = '0; ra = '0;
      s_wa = '0; s_nd = '0; s_be = '0; s_ra = '0;

      // Reset values.
      #2 rst_n = 1'b0;
      repeat (3) tick();
      check("rst_busy",  64'(init_busy), 64'd1);
      check("rst_conf",  64'(conf),      64'd0);
      check("rst_valid", 64'(rv),        64'd0);
      check("rst_dout",  dout[0] | dout[1] | dout[2], 64'd0);
      check("rst_s_busy", 64'(s_busy),   64'd1);

      // Test 1: init length after release, then every entry reads zero.
      rst_n = 1'b1;
      cycles = 0; s_cycles = 0;
      while (init_busy && cycles < 1000) begin
         if (s_busy) s_cycles++;
         tick();
         cycles++;
      end
      check("init_len",   64'(cycles),   64'd256);
      check("s_init_len", 64'(s_cycles), 64'd10);

      for (int a = 0; a < 256; a++) begin
         rd_en = 3'b111;
         ra    = {8'(a), 8'(a), 8'(a)};
         tick();
         check("init_rd", dout[0] | dout[1] | dout[2], 64'd0);
         check("init_rv", 64'(rv), 64'd7);
      end
      rd_en = '0;
      tick();
      check("rv_drop", 64'(rv), 64'd0);

      // Test 2: partial byte-enable overwrite.
      wr_en = 2'b01; wa[0] = 8'd5; nd[0] = 64'h1122_3344_5566_7788; be[0] = 8'hFF;
      tick();
      nd[0] = 64'hFFFF_FFFF_FFFF_FFFF; be[0] = 8'h0F;
      tick();
      check("be_conf", 64'(conf), 64'd0);
      wr_en = '0; rd_en = 3'b010; ra[1] = 8'd5;
      tick();
      check("be_data",  dout[1], 64'h1122_3344_FFFF_FFFF);
      check("be_valid", 64'(rv), 64'd2);
      rd_en = '0; ra[1] = 8'd7;
      tick();
      check("hold_data",  dout[1], 64'h1122_3344_FFFF_FFFF);
      check("hold_valid", 64'(rv), 64'd0);

      // Test 3: same-address overlap, port 1 wins upper lanes, port 0 flagged.
      wr_en = 2'b11; wa = {8'd7, 8'd7};
      nd = {VAL_B, VAL_A}; be = {8'hF0, 8'hFF};
      tick();
      check("conf_hit", 64'(conf), 64'd1);
      wr_en = '0;
      tick();
      check("conf_pulse", 64'(conf), 64'd0);
      rd_en = 3'b001; ra[0] = 8'd7;
      tick();
      check("merge_7", dout[0], {VAL_B[63:32], VAL_A[31:0]});
      rd_en = '0;

      // Same address, disjoint lanes: no conflict.
      wr_en = 2'b11; wa = {8'd8, 8'd8};
      nd = {VAL_D, VAL_C}; be = {8'h0F, 8'hF0};
      tick();
      check("disjoint_conf", 64'(conf), 64'd0);
      // Different addresses, full lanes: no conflict.
      wa = {8'd11, 8'd10}; be = {8'hFF, 8'hFF};
      tick();
      check("diffaddr_conf", 64'(conf), 64'd0);
      // Port 1 enabled with zero byte enables: no-op, no conflict.
      wa = {8'd12, 8'd12}; be = {8'h00, 8'hFF}; nd = {VAL_D, VAL_A};
      tick();
      check("be0_conf", 64'(conf), 64'd0);
      wr_en = '0; rd_en = 3'b111; ra = {8'd12, 8'd10, 8'd8};
      tick();
      check("disjoint_8", dout[0], {VAL_C[63:32], VAL_D[31:0]});
      check("diffaddr_10", dout[1], VAL_C);
      check("be0_12", dout[2], VAL_A);
      ra[0] = 8'd11;
      tick();
      check("diffaddr_11", dout[0], VAL_D);
      rd_en = '0;

      // Test 4: same-cycle read and write of addr 9.
      wr_en = 2'b01; wa[0] = 8'd9; nd[0] = 64'hA; be[0] = 8'hFF;
      tick();
      nd[0] = 64'hB; rd_en = 3'b100; ra[2] = 8'd9;
      tick();
`ifdef SRAM_WR_BYPASS_EN
      check("rw_same", dout[2], 64'hB);
`else
      check("rw_same", dout[2], 64'hA);
`endif
      wr_en = '0;
      tick();
      check("rw_after", dout[2], 64'hB);
      rd_en = '0;

      // Small instance: combinational read, out-of-range addresses.
      s_rd_en = 1'b1; s_ra[0] = 4'd9;
      #1;
      check("s_rd9",  64'(s_do[0]), 64'h5A5A);
      check("s_rv1",  64'(s_rv),    64'd1);
      s_rd_en = 1'b0;
      #1;
      check("s_rv0",  64'(s_rv),    64'd0);
      s_wr_en = 2'b11; s_wa = {4'd12, 4'd12}; s_nd = {16'hFFFF, 16'h0000}; s_be = {2'b11, 2'b11};
      tick();
      check("s_oor_conf", 64'(s_conf), 64'd0);
      s_wr_en = '0; s_rd_en = 1'b1; s_ra[0] = 4'd4;
      #1;
      check("s_alias4", 64'(s_do[0]), 64'h5A5A);
      s_ra[0] = 4'd12;
      #1;
      check("s_oor_rd", 64'(s_do[0]), 64'h0000);
      s_ra[0] = 4'd9; s_wr_en = 2'b01; s_wa[0] = 4'd9; s_nd[0] = 16'h1234; s_be[0] = 2'b01;
      #1;
`ifdef SRAM_WR_BYPASS_EN
      check("s_rw_same", 64'(s_do[0]), 64'h5A34);
`else
      check("s_rw_same", 64'(s_do[0]), 64'h5A5A);
`endif
      tick();
      s_wr_en = '0;
      #1;
      check("s_rw_after", 64'(s_do[0]), 64'h5A34);
      s_rd_en = 1'b0;

      // Test 5: re-init, with a late write dropped and init_req ignored mid-init.
      wr_en = 2'b10; wa[1] = 8'd3; nd[1] = 64'h33; be[1] = 8'hFF;
      tick();
      wr_en = '0; init_req = 1'b1;
      tick();
      init_req = 1'b0;
      check("reinit_busy", 64'(init_busy), 64'd1);
      cycles = 0;
      while (init_busy && cycles < 1000) begin
         init_req = (cycles == 100);
         if (cycles == 200) begin
            wr_en = 2'b10; wa[1] = 8'd3; nd[1] = 64'hDEAD; be[1] = 8'hFF;
            rd_en = 3'b001; ra[0] = 8'd3;
         end else begin
            wr_en = '0; rd_en = '0;
         end
         if (cycles == 201) begin
            check("init_rv0",   64'(rv),   64'd0);
            check("init_conf0", 64'(conf), 64'd0);
            check("init_rd3",   dout[0],   64'd0);
         end
         tick();
         cycles++;
      end
      quiet();
      check("reinit_len", 64'(cycles), 64'd256);
      rd_en = 3'b011; ra[0] = 8'd3; ra[1] = 8'd5;
      tick();
      check("drop_3",  dout[0], 64'd0);
      check("clear_5", dout[1], 64'd0);
      check("post_rv", 64'(rv), 64'd3);
      rd_en = '0;

      // Test 6: asynchronous reset at cnt=100, then a full restart.
      wr_en = 2'b01; wa[0] = 8'd9; nd[0] = 64'hB; be[0] = 8'hFF;
      tick();
      wr_en = '0; rd_en = 3'b100; ra[2] = 8'd9;
      tick();
      rd_en = '0; init_req = 1'b1;
      tick();
      init_req = 1'b0;
      repeat (100) tick();
      check("pre_rst_hold", dout[2], 64'hB);
      check("pre_rst_s_busy", 64'(s_busy), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dout",   dout[2],         64'd0);
      check("arst_busy",   64'(init_busy),  64'd1);
      check("arst_valid",  64'(rv),         64'd0);
      check("arst_s_busy", 64'(s_busy),     64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      cycles = 0;
      while (init_busy && cycles < 1000) begin
         tick();
         cycles++;
      end
      check("rst_init_len", 64'(cycles), 64'd256);
      rd_en = 3'b100; ra[2] = 8'd9;
      tick();
      check("rst_clear_9", dout[2], 64'd0);
      check("rst_rv",      64'(rv), 64'd4);
      quiet();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_mp_be_init.md
Name: sram_mp_be_init

Overview:
Generalised multi-ported SRAM with N write ports and M read ports, and per-byte write enables. Write-port priority is deterministic, and same-cycle write conflicts are reported. An on-chip init state machine clears the array after reset or on request, so no flop-reset array is needed. Read latency is selectable at 0 or 1 cycle. The block serves as the storage primitive for register files, tag/data arrays and vector lane buffers.

Parameters:
SIZE, 256, number of entries; any value >= 2, not necessarily a power of two.
DATA_WIDTH, 64, bits per entry; must be a multiple of 8.
RD_PORTS, 3, number of read ports.
WR_PORTS, 2, number of write ports.
READ_LATENCY, 1, 0 = combinational read, 1 = registered read.
INIT_VALUE, 0, DATA_WIDTH-wide value written to every entry by the init FSM.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
init_req  in  1  request re-initialisation; honoured only in IDLE.
init_busy  out  1  high while the init FSM is clearing the array.
wr_en  in  [WR_PORTS]  per-port write enable.
write_address  in  [WR_PORTS][$clog2(SIZE)]  write address.
new_data  in  [WR_PORTS][DATA_WIDTH]  write data.
wr_be  in  [WR_PORTS][DATA_WIDTH/8]  byte enables; bit k covers byte k.
wr_conflict  out  [WR_PORTS]  port lost at least one byte lane to a higher-priority port (registered, 1-cycle pulse).
rd_en  in  [RD_PORTS]  read enable.
read_address  in  [RD_PORTS][$clog2(SIZE)]  read address.
data_out  out  [RD_PORTS][DATA_WIDTH]  read data.
rd_valid  out  [RD_PORTS]  data_out holds valid data.

Behaviour:
- Reset values: init_busy=1, wr_conflict=0, rd_valid=0, data_out=0 (READ_LATENCY=1 registers only). The init FSM enters INIT with the counter at 0. Array contents are not reset.
- Init FSM:
  - INIT: writes INIT_VALUE to entry cnt each cycle, cnt++. When cnt==SIZE-1 is written, the FSM goes to IDLE on the next edge, so INIT lasts exactly SIZE cycles.
  - IDLE: init_req=1 moves the FSM to INIT with cnt=0 on the next edge. init_req during INIT is ignored; init does not restart.
  - rst_n asserted mid-INIT aborts immediately. After release, INIT restarts from cnt=0.
- Writes are ignored while init_busy=1, and no wr_conflict is raised.
- In IDLE, each byte lane of an entry takes data from the highest-index port with wr_en=1, matching address and wr_be lane set. Lanes with no enabled writer keep their old value. wr_be=0 with wr_en=1 is a no-op.
- wr_conflict[i] is set on the next edge iff port i wrote and a higher-index port overwrote at least one of its enabled lanes at the same address. Otherwise it is 0. The top port never conflicts.
- Write addresses >= SIZE are dropped with no effect. Read addresses >= SIZE return all zeros.
- READ_LATENCY=1: data_out[i] and rd_valid[i] update on the edge after rd_en[i]. rd_valid[i] = rd_en[i] & ~init_busy sampled at that edge. When rd_en[i]=0, data_out[i] holds its previous value.
- READ_LATENCY=0: data_out[i] = mem[read_address[i]] combinationally. rd_valid[i] = rd_en[i] & ~init_busy combinationally.
- Same-cycle read and write to the same address: the read returns the pre-write value (read-before-write), unless the optional feature is enabled.
- Reads during INIT return array contents, but rd_valid stays 0.

Optional Feature:
SRAM_WR_BYPASS_EN
- Defined: a read hitting an address written in the same cycle returns write-first data, with per-lane merge of the winning writers' bytes over the old value, using the same priority rule. With READ_LATENCY=0 this adds a combinational path from new_data/wr_be to data_out.
- Undefined: read-before-write, with no combinational path from write inputs to data_out.

Test Plan:
1. SIZE=256: release rst_n -> init_busy=1 for exactly 256 cycles, then 0. Reads of 0..255 return 0 with rd_valid=1 one cycle after rd_en.
2. Port0 writes 0x1122334455667788 to addr 5 with be=0xFF, then writes 0xFFFFFFFFFFFFFFFF with be=0x0F -> read addr 5 = 0x11223344FFFFFFFF.
3. Same cycle: port0 writes A to addr 7 with be=0xFF, and port1 writes B with be=0xF0 -> mem[7] = B[63:32]:A[31:0]. Next cycle wr_conflict=2'b01.
4. Addr 9 holds 0xA. Same cycle: write 0xB to addr 9 and read addr 9 -> data_out=0xA without the macro, 0xB with SRAM_WR_BYPASS_EN.
5. init_req in IDLE, then a write to addr 3 during INIT -> the write is dropped, rd_valid stays 0, and after 256 cycles mem[3]=INIT_VALUE.
6. Assert rst_n at cnt=100 -> outputs take reset values asynchronously. After release, INIT takes the full 256 cycles from cnt=0.
